camera_tx: RTL
==============

CAMERA_TX -- requirements
Module: camera_tx

Interface
REQ-001 SHALL have parameter H_ACT, default 640, active pixels per line; each pixel is 2 bytes.
REQ-002 SHALL have parameter H_BLANK, default 144, Pclk periods per line with Href low.
REQ-003 SHALL have parameter VSYNC_LINES, default 3, line periods with Vsync high.
REQ-004 SHALL have parameter VBP_LINES, default 17, blank line periods after Vsync.
REQ-005 SHALL have parameter V_ACT, default 480, active lines per frame.
REQ-006 SHALL have parameter VFP_LINES, default 10, blank line periods after the last active line.
REQ-007 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-008 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-009 SHALL have port en  input  1  frame generation enable.
REQ-010 SHALL have port PWDN  input  1  power-down, active-high.
REQ-011 SHALL have port pat  input  2  test pattern select.
REQ-012 SHALL have port Pclk  output  1  pixel clock, clk/2.
REQ-013 SHALL have port Vsync  output  1  frame sync, active-high.
REQ-014 SHALL have port Href  output  1  line valid, active-high.
REQ-015 SHALL have port Imagen  output  8  pixel byte.
REQ-016 SHALL have port frame_done  output  1  one-clk pulse at frame end.

Function
REQ-017 SHALL hold Pclk at 0 in IDLE and toggle it every clk in every other state.
REQ-018 SHALL update Vsync, Href, Imagen and all counters only on the clk edge where Pclk goes 1->0, so outputs are stable at each rising Pclk.
REQ-019 SHALL measure a line period as 2*H_ACT+H_BLANK Pclk periods.
REQ-020 SHALL sequence states IDLE -> VSYNC -> VBP -> ACTIVE -> VFP -> (VSYNC if en=1, else IDLE).
REQ-021 SHALL leave IDLE on the first clk with en=1 and PWDN=0.
REQ-022 SHALL hold VSYNC, VBP and VFP for VSYNC_LINES, VBP_LINES and VFP_LINES line periods respectively.
REQ-023 SHALL hold ACTIVE for V_ACT line periods.
REQ-024 SHALL drive Vsync=1 only in VSYNC.
REQ-025 SHALL drive Href=1 only in ACTIVE, for the first 2*H_ACT Pclk periods of each line, and 0 for the remaining H_BLANK.
REQ-026 SHALL hold Imagen=0 whenever Href=0.
REQ-027 SHALL use a per-line byte index b (0..2*H_ACT-1) and line index l (0..V_ACT-1).
REQ-028 SHALL, with Href=1, output Imagen as: pat=0 -> b mod 256; pat=1 -> 0xAA for even b, 0x55 for odd b; pat=2 -> l mod 256; pat=3 -> 0x00.
REQ-029 SHALL sample pat only at the start of each line; a change mid-line takes effect on the next line.
REQ-030 SHALL size counters for the defaults: byte/pixel counter 11 bits, line counter 10 bits, both wrapping to 0 at their terminal count.
REQ-031 SHALL pulse frame_done for exactly one clk on the edge that ends the last VFP line.
REQ-032 SHALL, when en falls mid-frame, finish the current frame and then enter IDLE.
REQ-033 SHALL, when PWDN=1, enter IDLE on the next clk from any state and clear all outputs and counters.
REQ-034 SHALL give PWDN priority over en when both are asserted.
REQ-035 SHALL start a fresh frame at VSYNC when PWDN falls while en=1.

Reset
REQ-036 SHALL, with Reset=0 at a rising clk, force IDLE and Pclk=Vsync=Href=frame_done=0, Imagen=0x00 and all counters to 0.
REQ-037 SHALL abort any frame in progress on reset and restart from VSYNC only after Reset=1 with en=1.

Verification
REQ-038 SHALL cover, with H_ACT=4, H_BLANK=2, VSYNC_LINES=1, VBP_LINES=1, V_ACT=2, VFP_LINES=1: en=1, pat=0 -> 10-Pclk lines; Vsync high 10 Pclk; 2 lines each with Href high 8 Pclk carrying 0x00..0x07; frame_done every 100 clk.
REQ-039 SHALL cover pat=1 -> each Href burst reads AA,55,AA,55,AA,55,AA,55; pat=2 -> line 0 all 0x00, line 1 all 0x01.
REQ-040 SHALL cover pat changed from 0 to 3 mid-line -> current line completes with counter data, next line is 0x00.
REQ-041 SHALL cover en dropped during VBP -> active lines and VFP complete, one frame_done, then Pclk stays 0.
REQ-042 SHALL cover PWDN pulsed during ACTIVE -> next clk all outputs 0; after PWDN falls, Vsync rises within 2 clk.
REQ-043 SHALL cover Reset=0 asserted mid-line -> outputs and Pclk 0 on the next clk; frame restarts from VSYNC after release.

Source files
------------

// File: rtl/camera_tx.sv
// camera_tx: OV-style camera timing generator (Pclk/Vsync/Href/Imagen) with test patterns
module camera_tx #(
  parameter int H_ACT       = 640,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int V_ACT       = 480,
  parameter int VFP_LINES   = 10
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       en,
  input  logic       PWDN,
  input  logic [1:0] pat,
  output logic       Pclk,
  output logic       Vsync,
  output logic       Href,
  output logic [7:0] Imagen,
  output logic       frame_done
);
  localparam logic [10:0] HLAST = 11'(2*H_ACT+H_BLANK-1);
  localparam logic [10:0] HACT2 = 11'(2*H_ACT);
  localparam logic [9:0]  L_VS  = 10'(VSYNC_LINES-1);
  localparam logic [9:0]  L_VBP = 10'(VBP_LINES-1);
  localparam logic [9:0]  L_ACT = 10'(V_ACT-1);
  localparam logic [9:0]  L_VFP = 10'(VFP_LINES-1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;
  state_t      state, state_n;
  logic [10:0] h, h_n;
  logic [9:0]  l, l_n, llast;
  logic [1:0]  p, p_n;
  logic        tick, eol, eos, done_n, href_n;
  logic [7:0]  pix;

  // tick marks the clk edge where Pclk falls; all timing advances only there
  always_comb begin
    tick = Pclk;
    eol = tick && h == HLAST;
    llast = state == VSYNC ? L_VS : state == VBP ? L_VBP : state == ACTIVE ? L_ACT : L_VFP;
    eos = eol && l == llast;
    done_n = eos && state == VFP;
    state_n = state;
    h_n = h;
    l_n = l;
    p_n = p;
    if (state == IDLE) begin
      if (en) begin
        state_n = VSYNC;
        h_n = '0;
        l_n = '0;
        p_n = pat;
      end
    end else if (tick) begin
      h_n = eol ? '0 : h + 11'd1;
      if (eol) begin
        l_n = eos ? '0 : l + 10'd1;
        p_n = pat;
      end
      if (eos)
        case (state)
          VSYNC:   state_n = VBP;
          VBP:     state_n = ACTIVE;
          ACTIVE:  state_n = VFP;
          default: state_n = en ? VSYNC : IDLE;
        endcase
    end
    href_n = state_n == ACTIVE && h_n < HACT2;
    pix = p_n == 2'd0 ? h_n[7:0] : p_n == 2'd1 ? (h_n[0] ? 8'h55 : 8'hAA) : p_n == 2'd2 ? l_n[7:0] : 8'h00;
  end

  always_ff @(posedge clk)
    if (!Reset || PWDN) begin
      state <= IDLE;
      h <= '0;
      l <= '0;
      p <= '0;
      Pclk <= 1'b0;
      Vsync <= 1'b0;
      Href <= 1'b0;
      Imagen <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      h <= h_n;
      l <= l_n;
      p <= p_n;
      Pclk <= (state != IDLE && state_n != IDLE) ? ~Pclk : 1'b0;
      Vsync <= state_n == VSYNC;
      Href <= href_n;
      Imagen <= href_n ? pix : 8'h00;
      frame_done <= done_n;
    end
endmodule
